// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin issue,
// one-deep registered response per requester, one operation per cycle overall.

package alu_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flag_t;

endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  alu_op_e                   req0_op,
    input  logic [DATA_BUS_WIDTH-1:0] req0_a,
    input  logic [DATA_BUS_WIDTH-1:0] req0_b,
    output logic                      rsp0_valid,
    input  logic                      rsp0_ready,
    output logic [DATA_BUS_WIDTH-1:0] rsp0_result,
    output alu_flag_t                 rsp0_flag,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  alu_op_e                   req1_op,
    input  logic [DATA_BUS_WIDTH-1:0] req1_a,
    input  logic [DATA_BUS_WIDTH-1:0] req1_b,
    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
    output logic [DATA_BUS_WIDTH-1:0] rsp1_result,
    output alu_flag_t                 rsp1_flag,

    output alu_op_e                   alu_op,
    output logic [DATA_BUS_WIDTH-1:0] alu_register1,
    output logic [DATA_BUS_WIDTH-1:0] alu_register2,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  alu_flag_t                 alu_flag,

    output logic                      grant_valid,
    output logic                      grant_id
);

    logic                      elig0_s;
    logic                      elig1_s;
    logic                      grant_valid_s;
    logic                      grant_id_s;
    logic                      grant0_s;
    logic                      grant1_s;
    logic                      rr_ptr_r;

    logic                      rsp0_valid_r;
    logic [DATA_BUS_WIDTH-1:0] rsp0_result_r;
    alu_flag_t                 rsp0_flag_r;
    logic                      rsp1_valid_r;
    logic [DATA_BUS_WIDTH-1:0] rsp1_result_r;
    alu_flag_t                 rsp1_flag_r;

    // Eligibility and round-robin grant; a held response that drains this cycle frees its slot.
    always_comb begin
        elig0_s       = req0_valid & (~rsp0_valid_r | rsp0_ready);
        elig1_s       = req1_valid & (~rsp1_valid_r | rsp1_ready);
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (!rst_n) begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end else begin
            case ({elig1_s, elig0_s})
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = rr_ptr_r;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_id_s    = 1'b0;
                end
            endcase
        end
    end

    assign grant0_s    = grant_valid_s & ~grant_id_s;
    assign grant1_s    = grant_valid_s & grant_id_s;
    assign grant_valid = grant_valid_s;
    assign grant_id    = grant_id_s;
    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;

    // Steer the granted operation onto the shared ALU; idle operands are forced to zero.
    always_comb begin
        alu_op        = req0_op;
        alu_register1 = {DATA_BUS_WIDTH{1'b0}};
        alu_register2 = {DATA_BUS_WIDTH{1'b0}};
        if (grant1_s) begin
            alu_op        = req1_op;
            alu_register1 = req1_a;
            alu_register2 = req1_b;
        end else if (grant0_s) begin
            alu_op        = req0_op;
            alu_register1 = req0_a;
            alu_register2 = req0_b;
        end else begin
            alu_op        = req0_op;
            alu_register1 = {DATA_BUS_WIDTH{1'b0}};
            alu_register2 = {DATA_BUS_WIDTH{1'b0}};
        end
    end

    // Round-robin pointer: favour the other requester after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (grant_valid_s) begin
            rr_ptr_r <= ~grant_id_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Requester 0 response slot: a new grant wins over a drain, so reissue has no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_r  <= 1'b0;
            rsp0_result_r <= {DATA_BUS_WIDTH{1'b0}};
            rsp0_flag_r   <= alu_flag_t'(4'b0000);
        end else if (grant0_s) begin
            rsp0_valid_r  <= 1'b1;
            rsp0_result_r <= alu_result;
            rsp0_flag_r   <= alu_flag;
        end else if (rsp0_ready) begin
            rsp0_valid_r  <= 1'b0;
        end else begin
            rsp0_valid_r  <= rsp0_valid_r;
        end
    end

    // Requester 1 response slot, same policy as requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid_r  <= 1'b0;
            rsp1_result_r <= {DATA_BUS_WIDTH{1'b0}};
            rsp1_flag_r   <= alu_flag_t'(4'b0000);
        end else if (grant1_s) begin
            rsp1_valid_r  <= 1'b1;
            rsp1_result_r <= alu_result;
            rsp1_flag_r   <= alu_flag;
        end else if (rsp1_ready) begin
            rsp1_valid_r  <= 1'b0;
        end else begin
            rsp1_valid_r  <= rsp1_valid_r;
        end
    end

    assign rsp0_valid  = rsp0_valid_r;
    assign rsp0_result = rsp0_result_r;
    assign rsp0_flag   = rsp0_flag_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp1_result = rsp1_result_r;
    assign rsp1_flag   = rsp1_flag_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table plus hand sequences and a random scoreboard run for alu_arbiter.

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    alu_op_e    req0_op, req1_op, alu_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_result, rsp1_result;
    alu_flag_t  rsp0_flag, rsp1_flag, alu_flag;
    logic [7:0] alu_register1, alu_register2, alu_result;
    logic       grant_valid, grant_id;
    logic [3:0] f0, f1;
    logic [11:0] alu_m;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flag(rsp0_flag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flag(rsp1_flag),
        .alu_op(alu_op), .alu_register1(alu_register1), .alu_register2(alu_register2),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {carry, zero, negative, overflow, result}
    function automatic logic [11:0] alu_f(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        c = 1'b0; v = 1'b0; w = 9'd0; r = 8'd0;
        case (op)
            ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                           v = (a[7] == b[7]) && (r[7] != a[7]); end
            ALU_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                           v = (a[7] != b[7]) && (r[7] != a[7]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
            ALU_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: r = a;
        endcase
        return {c, (r == 8'd0), r[7], v, r};
    endfunction

    always_comb begin
        alu_m      = alu_f(alu_op, alu_register1, alu_register2);
        alu_result = alu_m[7:0];
        alu_flag   = alu_flag_t'(alu_m[11:8]);
    end

    assign f0 = rsp0_flag;
    assign f1 = rsp1_flag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input alu_op_e op0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input alu_op_e op1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic r0, input logic r1);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    typedef struct {
        logic v0; alu_op_e op0; logic [7:0] a0; logic [7:0] b0;
        logic v1; alu_op_e op1; logic [7:0] a1; logic [7:0] b1;
        logic rdy0; logic rdy1;
        logic gv; logic gid;
        logic ev0; logic [7:0] er0; logic [3:0] ef0;
        logic ev1; logic [7:0] er1; logic [3:0] ef1;
    } vec_t;

    vec_t vecs[10];

    logic [11:0] q0[$];
    logic [11:0] q1[$];

    initial begin : main
        logic [11:0] e;
        logic        m_rv0, m_rv1, m_rr, e0, e1, gv, gid, r0, r1;
        logic [7:0]  ea;
        alu_op_e     eop;

        // Sequence from reset; expectations worked by hand from the grant and response rules.
        vecs[0] = '{1'b1, ALU_ADD,  8'h12, 8'h34, 1'b0, ALU_ADD, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h46, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vecs[1] = '{1'b1, ALU_SUB,  8'h10, 8'h20, 1'b1, ALU_AND, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h46, 4'b0000, 1'b1, 8'h30, 4'b0000};
        vecs[2] = '{1'b1, ALU_SUB,  8'h10, 8'h20, 1'b1, ALU_OR,  8'h0F, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 4'b1010, 1'b0, 8'h30, 4'b0000};
        vecs[3] = '{1'b1, ALU_XOR,  8'hAA, 8'h55, 1'b1, ALU_OR,  8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF0, 4'b1010, 1'b1, 8'hFF, 4'b0010};
        vecs[4] = '{1'b1, ALU_XOR,  8'hAA, 8'h55, 1'b1, ALU_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 4'b1010, 1'b1, 8'hFF, 4'b0010};
        vecs[5] = '{1'b1, ALU_XOR,  8'hAA, 8'h55, 1'b1, ALU_ADD, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 4'b0010, 1'b1, 8'hFF, 4'b0010};
        vecs[6] = '{1'b0, ALU_XOR,  8'hAA, 8'h55, 1'b1, ALU_ADD, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'b0010, 1'b1, 8'h00, 4'b1100};
        vecs[7] = '{1'b0, ALU_ADD,  8'h00, 8'h00, 1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4'b0010, 1'b0, 8'h00, 4'b1100};
        vecs[8] = '{1'b0, ALU_ADD,  8'h00, 8'h00, 1'b1, ALU_SHL, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'b0010, 1'b1, 8'h02, 4'b1000};
        vecs[9] = '{1'b1, ALU_PASS, 8'h7E, 8'h00, 1'b1, ALU_SHR, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7E, 4'b0000, 1'b1, 8'h02, 4'b1000};

        rst_n = 1'b0;
        drive(1'b1, ALU_ADD, 8'h01, 8'h02, 1'b1, ALU_ADD, 8'h03, 8'h04, 1'b1, 1'b1);
        #3;
        chk("reset rsp0_valid", 32'(rsp0_valid), 32'(1'b0));
        chk("reset rsp1_valid", 32'(rsp1_valid), 32'(1'b0));
        chk("reset rsp0_result", 32'(rsp0_result), 32'(8'h00));
        chk("reset rsp1_flag", 32'(f1), 32'(4'b0000));
        chk("reset grant_valid", 32'(grant_valid), 32'(1'b0));
        chk("reset req0_ready", 32'(req0_ready), 32'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rdy0, vecs[i].rdy1);
            @(negedge clk);
            chk($sformatf("vec%0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].gv));
            chk($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
            chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].gv & ~vecs[i].gid));
            chk($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].gv & vecs[i].gid));
            ea = !vecs[i].gv ? 8'h00 : (vecs[i].gid ? vecs[i].a1 : vecs[i].a0);
            chk($sformatf("vec%0d alu_register1", i), 32'(alu_register1), 32'(ea));
            @(posedge clk); #1;
            chk($sformatf("vec%0d rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].ev0));
            chk($sformatf("vec%0d rsp0_result", i), 32'(rsp0_result), 32'(vecs[i].er0));
            chk($sformatf("vec%0d rsp0_flag", i), 32'(f0), 32'(vecs[i].ef0));
            chk($sformatf("vec%0d rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].ev1));
            chk($sformatf("vec%0d rsp1_result", i), 32'(rsp1_result), 32'(vecs[i].er1));
            chk($sformatf("vec%0d rsp1_flag", i), 32'(f1), 32'(vecs[i].ef1));
        end

        // Backpressure: rsp1 held and not consumed, req0 keeps flowing.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ALU_ADD, 8'(k), 8'h10, 1'b1, ALU_XOR, 8'h11, 8'h22, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("bp%0d grant_valid", k), 32'(grant_valid), 32'(1'b1));
            chk($sformatf("bp%0d grant_id", k), 32'(grant_id), 32'(1'b0));
            chk($sformatf("bp%0d req1_ready", k), 32'(req1_ready), 32'(1'b0));
            @(posedge clk); #1;
            chk($sformatf("bp%0d rsp1_result", k), 32'(rsp1_result), 32'(8'h02));
            chk($sformatf("bp%0d rsp1_valid", k), 32'(rsp1_valid), 32'(1'b1));
            chk($sformatf("bp%0d rsp0_result", k), 32'(rsp0_result), 32'(8'h10 + 8'(k)));
        end

        // Asynchronous reset mid-cycle with both responses held.
        drive(1'b1, ALU_ADD, 8'h05, 8'h06, 1'b1, ALU_SUB, 8'h40, 8'h01, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst rsp0_valid", 32'(rsp0_valid), 32'(1'b0));
        chk("arst rsp1_valid", 32'(rsp1_valid), 32'(1'b0));
        chk("arst rsp0_result", 32'(rsp0_result), 32'(8'h00));
        chk("arst grant_valid", 32'(grant_valid), 32'(1'b0));
        chk("arst req0_ready", 32'(req0_ready), 32'(1'b0));
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Contention from reset: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ALU_ADD, 8'(k), 8'h01, 1'b1, ALU_SUB, 8'h40, 8'(k), 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("rr%0d grant_valid", k), 32'(grant_valid), 32'(1'b1));
            chk($sformatf("rr%0d grant_id", k), 32'(grant_id), 32'(k % 2));
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                e = alu_f(ALU_ADD, 8'(k), 8'h01);
                chk($sformatf("rr%0d rsp0_result", k), 32'(rsp0_result), 32'(e[7:0]));
            end else begin
                e = alu_f(ALU_SUB, 8'h40, 8'(k));
                chk($sformatf("rr%0d rsp1_result", k), 32'(rsp1_result), 32'(e[7:0]));
            end
        end

        // Random traffic against an independent model and per-requester scoreboard.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rr = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(3, 0) != 0), alu_op_e'(3'($urandom_range(7, 0))), 8'($urandom()), 8'($urandom()),
                  1'($urandom_range(3, 0) != 0), alu_op_e'(3'($urandom_range(7, 0))), 8'($urandom()), 8'($urandom()),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            @(negedge clk);
            r0  = rsp0_ready;
            r1  = rsp1_ready;
            e0  = req0_valid & (~m_rv0 | r0);
            e1  = req1_valid & (~m_rv1 | r1);
            gv  = e0 | e1;
            gid = (e0 & e1) ? m_rr : e1;
            chk("rnd rsp0_valid", 32'(rsp0_valid), 32'(m_rv0));
            chk("rnd rsp1_valid", 32'(rsp1_valid), 32'(m_rv1));
            chk("rnd grant_valid", 32'(grant_valid), 32'(gv));
            chk("rnd grant_id", 32'(grant_id), 32'(gv & gid));
            eop = (gv & gid) ? req1_op : req0_op;
            chk("rnd alu_op", 32'(alu_op), 32'(eop));
            if (m_rv0 && r0) begin
                if (q0.size() == 0) begin
                    chk("rnd q0 underflow", 32'(1), 32'(0));
                end else begin
                    e = q0.pop_front();
                    chk("rnd rsp0 data", 32'({f0, rsp0_result}), 32'(e));
                end
            end
            if (m_rv1 && r1) begin
                if (q1.size() == 0) begin
                    chk("rnd q1 underflow", 32'(1), 32'(0));
                end else begin
                    e = q1.pop_front();
                    chk("rnd rsp1 data", 32'({f1, rsp1_result}), 32'(e));
                end
            end
            if (gv && !gid) q0.push_back(alu_f(req0_op, req0_a, req0_b));
            if (gv &&  gid) q1.push_back(alu_f(req1_op, req1_a, req1_b));
            m_rv0 = (gv && !gid) ? 1'b1 : (r0 ? 1'b0 : m_rv0);
            m_rv1 = (gv &&  gid) ? 1'b1 : (r1 ? 1'b0 : m_rv1);
            m_rr  = gv ? ~gid : m_rr;
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
